// File: rtl/arb_defs.sv
// Shared definitions for the single-port SRAM arbiter: FSM encodings and the
// default wait-state count.
package arb_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC_D = 2'd1,
    ACC_I = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_WAIT_CYCLES = 1;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Serialises instruction fetches and MEM-stage loads/stores onto one SRAM port
// with data-side priority and a programmable wait-state count.
module mem_arbiter
  import arb_defs::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
  localparam int unsigned SEL_W      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ready_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [SEL_W-1:0]  mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_ready_o,
  output logic              stallreq_o,
  output logic              sram_ce_o,
  output logic              sram_we_o,
  output logic [SEL_W-1:0]  sram_sel_o,
  output logic [ADDR_W-3:0] sram_addr_o,
  output logic [DATA_W-1:0] sram_wdata_o,
  input  logic [DATA_W-1:0] sram_rdata_i
);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sram_ce_d, sram_we_d;
  logic [SEL_W-1:0]  sram_sel_d;
  logic [ADDR_W-3:0] sram_addr_d;
  logic [DATA_W-1:0] sram_wdata_d;
  logic [DATA_W-1:0] if_data_d, mem_data_d;
  logic              if_ready_d, mem_ready_d;
  logic              unused_addr_lsb;

  // Word addressing: byte lanes are selected only by sel.
  assign unused_addr_lsb = ^{if_addr_i[1:0], mem_addr_i[1:0]};

  // Held low during reset so every output reads 0 while rst is asserted.
  assign stallreq_o = ~rst & ((if_ce_i & ~if_ready_o) | (mem_ce_i & ~mem_ready_o));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sram_ce_d    = sram_ce_o;
    sram_we_d    = sram_we_o;
    sram_sel_d   = sram_sel_o;
    sram_addr_d  = sram_addr_o;
    sram_wdata_d = sram_wdata_o;
    if_data_d    = if_data_o;
    mem_data_d   = mem_data_o;
    if_ready_d   = 1'b0;
    mem_ready_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // A requester whose ready is pulsing this cycle is not re-granted.
        if (mem_ce_i && !mem_ready_o) begin
          state_d      = ACC_D;
          cnt_d        = CNT_W'(WAIT_CYCLES);
          sram_ce_d    = 1'b1;
          sram_we_d    = mem_we_i;
          sram_sel_d   = mem_sel_i;
          sram_addr_d  = mem_addr_i[ADDR_W-1:2];
          sram_wdata_d = mem_data_i;
        end else if (if_ce_i && !if_ready_o) begin
          state_d      = ACC_I;
          cnt_d        = CNT_W'(WAIT_CYCLES);
          sram_ce_d    = 1'b1;
          sram_we_d    = 1'b0;
          sram_sel_d   = '1;
          sram_addr_d  = if_addr_i[ADDR_W-1:2];
          sram_wdata_d = mem_data_i;
        end
      end
      ACC_D, ACC_I: begin
        if (cnt_q == '0) begin
          state_d    = IDLE;
          sram_ce_d  = 1'b0;
          sram_we_d  = 1'b0;
          sram_sel_d = '0;
          if (state_q == ACC_D) begin
            mem_ready_d = 1'b1;
            if (!sram_we_o) begin
              mem_data_d = sram_rdata_i;
            end
          end else begin
            if_ready_d = 1'b1;
            if_data_d  = sram_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sram_ce_o    <= 1'b0;
      sram_we_o    <= 1'b0;
      sram_sel_o   <= '0;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      if_data_o    <= '0;
      mem_data_o   <= '0;
      if_ready_o   <= 1'b0;
      mem_ready_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sram_ce_o    <= sram_ce_d;
      sram_we_o    <= sram_we_d;
      sram_sel_o   <= sram_sel_d;
      sram_addr_o  <= sram_addr_d;
      sram_wdata_o <= sram_wdata_d;
      if_data_o    <= if_data_d;
      mem_data_o   <= mem_data_d;
      if_ready_o   <= if_ready_d;
      mem_ready_o  <= mem_ready_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a WAIT_CYCLES=1 instance and a WAIT_CYCLES=0
// instance, with ready pulses matched against a queue of expected completions.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;

  logic        if_ce, mem_ce, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata, rdata;
  logic [3:0]  mem_sel;
  logic [31:0] if_data, mem_data, sram_addr_w, sram_wdata;
  logic        if_ready, mem_ready, stall, sram_ce, sram_we;
  logic [3:0]  sram_sel;
  logic [29:0] sram_addr;

  logic        if_ce1;
  logic [31:0] if_addr1, rdata1, if_data1, mem_data1, sram_wdata1;
  logic        if_ready1, mem_ready1, stall1, sram_ce1, sram_we1;
  logic [3:0]  sram_sel1;
  logic [29:0] sram_addr1;
  logic        mem_ce1, mem_we1;
  logic [3:0]  mem_sel1;
  logic [31:0] mem_addr1, mem_wdata1;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce), .if_addr_i(if_addr), .if_data_o(if_data), .if_ready_o(if_ready),
    .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_sel_i(mem_sel), .mem_addr_i(mem_addr),
    .mem_data_i(mem_wdata), .mem_data_o(mem_data), .mem_ready_o(mem_ready),
    .stallreq_o(stall), .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_sel_o(sram_sel),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .if_ce_i(if_ce1), .if_addr_i(if_addr1), .if_data_o(if_data1), .if_ready_o(if_ready1),
    .mem_ce_i(mem_ce1), .mem_we_i(mem_we1), .mem_sel_i(mem_sel1), .mem_addr_i(mem_addr1),
    .mem_data_i(mem_wdata1), .mem_data_o(mem_data1), .mem_ready_o(mem_ready1),
    .stallreq_o(stall1), .sram_ce_o(sram_ce1), .sram_we_o(sram_we1), .sram_sel_o(sram_sel1),
    .sram_addr_o(sram_addr1), .sram_wdata_o(sram_wdata1), .sram_rdata_i(rdata1)
  );

  assign sram_addr_w = {2'b00, sram_addr};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // kind: 0 = fetch on u_dut, 1 = data on u_dut, 2 = fetch on u_dut0
  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_cmp;
  int   n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic expect_ready(input int kind, input logic [31:0] data, input int at);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  // Match every ready pulse seen this cycle against the scoreboard.
  task automatic check_ready();
    logic [2:0]  seen;
    logic [31:0] obs;
    bit          found;
    seen = {if_ready1, mem_ready, if_ready};
    for (int k = 0; k < 3; k++) begin
      if (seen[k]) begin
        obs   = (k == 0) ? if_data : (k == 1) ? mem_data : if_data1;
        found = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (!found && sb[i].kind == k && sb[i].cyc == cyc) begin
            chk($sformatf("ready_data_k%0d", k), obs, sb[i].data);
            sb.delete(i);
            found = 1'b1;
          end
        end
        if (!found) chk($sformatf("unexpected_ready_k%0d", k), 32'd1, 32'd0);
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        chk($sformatf("missing_ready_k%0d", sb[i].kind), 32'd0, 32'd1);
        sb.delete(i);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    check_ready();
  endtask

  task automatic settle();
    #1;
  endtask

  int          t;
  logic [31:0] held_mem_data;

  initial begin
    cyc = 0; n_cmp = 0; n_err = 0;
    rst = 1'b1;
    if_ce = 0; if_addr = 0; mem_ce = 0; mem_we = 0; mem_sel = 0; mem_addr = 0;
    mem_wdata = 0; rdata = 0;
    if_ce1 = 0; if_addr1 = 0; rdata1 = 0;
    mem_ce1 = 0; mem_we1 = 0; mem_sel1 = 0; mem_addr1 = 0; mem_wdata1 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset state
    chk("rst_sram_ce", 32'(sram_ce), 32'd0);
    chk("rst_sram_addr", sram_addr_w, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_u0_outs", 32'({sram_ce1, sram_we1, sram_sel1, if_ready1, mem_ready1, stall1}), 32'd0);
    rst = 1'b0;
    tick();

    // Lone fetch
    t = cyc;
    if_ce = 1; if_addr = 32'h0000_0010; rdata = 32'h3C01_1234;
    settle();
    chk("fetch_stall_t", 32'(stall), 32'd1);
    expect_ready(0, 32'h3C01_1234, t + 3);
    tick();
    chk("fetch_ce_t1", 32'(sram_ce), 32'd1);
    chk("fetch_addr_t1", sram_addr_w, 32'h4);
    chk("fetch_sel_t1", 32'(sram_sel), 32'hF);
    chk("fetch_stall_t1", 32'(stall), 32'd1);
    tick();
    chk("fetch_ce_t2", 32'(sram_ce), 32'd1);
    chk("fetch_stall_t2", 32'(stall), 32'd1);
    tick();
    chk("fetch_ready_t3", 32'(if_ready), 32'd1);
    chk("fetch_stall_t3", 32'(stall), 32'd0);
    chk("fetch_ce_t3", 32'(sram_ce), 32'd0);
    if_ce = 0;
    tick();

    // Simultaneous fetch and load: data first
    t = cyc;
    if_ce = 1; if_addr = 32'h0000_0020;
    mem_ce = 1; mem_we = 0; mem_sel = 4'hF; mem_addr = 32'h0000_0100;
    rdata = 32'hAAAA_0001;
    expect_ready(1, 32'hAAAA_0001, t + 3);
    expect_ready(0, 32'hBBBB_0002, t + 6);
    tick();
    chk("sim_d_addr", sram_addr_w, 32'h40);
    chk("sim_d_we", 32'(sram_we), 32'd0);
    tick();
    tick();
    chk("sim_mem_ready", 32'(mem_ready), 32'd1);
    chk("sim_stall_t3", 32'(stall), 32'd1);
    mem_ce = 0; rdata = 32'hBBBB_0002;
    tick();
    chk("sim_i_addr", sram_addr_w, 32'h8);
    chk("sim_i_sel", 32'(sram_sel), 32'hF);
    tick();
    tick();
    chk("sim_if_ready", 32'(if_ready), 32'd1);
    chk("sim_stall_t6", 32'(stall), 32'd0);
    if_ce = 0;
    tick();

    // Byte store: load data register must keep its value
    held_mem_data = 32'hAAAA_0001;
    t = cyc;
    mem_ce = 1; mem_we = 1; mem_sel = 4'b0100; mem_addr = 32'h8000_0006;
    mem_wdata = 32'h0000_00AB; rdata = 32'hFFFF_FFFF;
    expect_ready(1, held_mem_data, t + 3);
    tick();
    chk("st_we", 32'(sram_we), 32'd1);
    chk("st_sel", 32'(sram_sel), 32'b0100);
    chk("st_addr", sram_addr_w, 32'h2000_0001);
    chk("st_wdata", sram_wdata, 32'h0000_00AB);
    tick();
    tick();
    mem_ce = 0;
    tick();
    chk("st_hold_addr", sram_addr_w, 32'h2000_0001);
    chk("st_hold_wdata", sram_wdata, 32'h0000_00AB);
    chk("st_idle_we", 32'(sram_we), 32'd0);

    // Write whose ce drops mid-access still completes once
    t = cyc;
    mem_ce = 1; mem_we = 1; mem_sel = 4'hF; mem_addr = 32'h0000_0040;
    mem_wdata = 32'hDEAD_BEEF;
    expect_ready(1, held_mem_data, t + 3);
    tick();
    mem_ce = 0; mem_wdata = 32'h1111_1111;
    settle();
    chk("drop_stall", 32'(stall), 32'd0);
    tick();
    chk("drop_we_t2", 32'(sram_we), 32'd1);
    chk("drop_wdata_t2", sram_wdata, 32'hDEAD_BEEF);
    tick();
    tick();
    chk("drop_idle_ce", 32'(sram_ce), 32'd0);
    tick();
    tick();

    // Reset during ACC_I abandons the fetch
    if_ce = 1; if_addr = 32'h0000_0030; rdata = 32'h5555_5555;
    tick();
    chk("rsti_ce_before", 32'(sram_ce), 32'd1);
    rst = 1; if_ce = 0;
    settle();
    chk("rsti_ctrl", 32'({sram_ce, sram_we, sram_sel, if_ready, mem_ready, stall}), 32'd0);
    chk("rsti_addr", sram_addr_w, 32'd0);
    chk("rsti_wdata", sram_wdata, 32'd0);
    chk("rsti_data", if_data | mem_data, 32'd0);
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) tick();

    t = cyc;
    if_ce = 1; if_addr = 32'h0000_0044; rdata = 32'h0BAD_F00D;
    expect_ready(0, 32'h0BAD_F00D, t + 3);
    tick();
    chk("post_rst_addr", sram_addr_w, 32'h11);
    tick();
    tick();
    if_ce = 0;
    tick();

    // Zero wait states on the second instance
    t = cyc;
    if_ce1 = 1; if_addr1 = 32'h0000_0008; rdata1 = 32'h1234_5678;
    expect_ready(2, 32'h1234_5678, t + 2);
    tick();
    chk("w0_ce_t1", 32'(sram_ce1), 32'd1);
    chk("w0_addr_t1", {2'b00, sram_addr1}, 32'h2);
    tick();
    chk("w0_ready_t2", 32'(if_ready1), 32'd1);
    chk("w0_stall_t2", 32'(stall1), 32'd0);
    if_ce1 = 0;
    tick();
    t = cyc;
    if_ce1 = 1; if_addr1 = 32'h0000_00FC; rdata1 = 32'hCAFE_0000;
    expect_ready(2, 32'hCAFE_0000, t + 2);
    tick();
    chk("w0_addr_b", {2'b00, sram_addr1}, 32'h3F);
    tick();
    if_ce1 = 0;
    tick();
    tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("u0_mem_idle", 32'({mem_ready1, sram_we1}) | mem_data1 | sram_wdata1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
